// File: rtl/cryptarch_pkg.sv
// cryptarch_pkg: types and constants shared across the cipher datapath.
//   state_t  128-bit block/key. Bytes in FIPS-197 order, byte 0 in the MSBs,
//            so word c of the state sits at bits [127-32c -: 32].
//   word_t   32-bit column word.
//   RCON     round constants 1..NR_MAX.
//   sbox()   forward AES S-box. The substitution stage uses the same function.
//   ks_state_t  key-schedule FSM encoding.
package cryptarch_pkg;

    localparam int NR_MAX = 10;

    typedef logic [7:0][3:0][3:0] state_t;
    typedef logic [31:0]          word_t;

    typedef enum logic {KS_IDLE, KS_EMIT} ks_state_t;

    localparam logic [1:NR_MAX][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_schedule_if.sv
// key_schedule_if: key-in / round-key-out handshake bundle.
//   slave  : the key schedule (takes key_in, drives rk*)
//   master : the key source and the round stage that consumes rk
//   KSCHED_CACHE_EN adds replay/rev (master -> slave).
interface key_schedule_if #(parameter int IDX_W = 4) ();
    logic                  in_valid;
    logic                  in_ready;
    cryptarch_pkg::state_t key_in;
    logic                  rk_valid;
    logic                  rk_ready;
    cryptarch_pkg::state_t rk;
    logic [IDX_W-1:0]      rk_idx;
    logic                  rk_last;
`ifdef KSCHED_CACHE_EN
    logic                  replay;
    logic                  rev;

    modport master (output in_valid, key_in, rk_ready, replay, rev,
                    input  in_ready, rk_valid, rk, rk_idx, rk_last);
    modport slave  (input  in_valid, key_in, rk_ready, replay, rev,
                    output in_ready, rk_valid, rk, rk_idx, rk_last);
`else
    modport master (output in_valid, key_in, rk_ready,
                    input  in_ready, rk_valid, rk, rk_idx, rk_last);
    modport slave  (input  in_valid, key_in, rk_ready,
                    output in_ready, rk_valid, rk, rk_idx, rk_last);
`endif
endinterface

// File: rtl/key_schedule_subword.sv
// ks_subword: AES SubWord. Each of the four bytes goes through its own
// combinational S-box lookup.
//   w  in   32  input word
//   o  out  32  substituted word
module ks_subword
    import cryptarch_pkg::*;
(
    input  word_t w,
    output word_t o
);
    localparam int NUM_LANES = 4;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign o[8*i +: 8] = sbox(w[8*i +: 8]);
    end
endmodule

// File: rtl/key_schedule.sv
// key_schedule: iterative AES-128 key expander. It accepts one cipher key and
// then emits round keys 0..NR, one per rk handshake. Only one round key is
// held at a time, and each next key is computed from it in a single cycle.
//   clk, rst   clock; synchronous active-high reset
//   bus        key_schedule_if.slave: in_valid/in_ready/key_in, then
//              rk_valid/rk_ready/rk/rk_idx/rk_last
// Optional macro KSCHED_CACHE_EN keeps all NR+1 keys in a register file.
// With it, replay=1 in IDLE re-emits the cached keys in forward order
// (rev=0) or reverse order (rev=1).
module key_schedule
    import cryptarch_pkg::*;
#(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input logic          clk,
    input logic          rst,
    key_schedule_if.slave bus
);
    if (NR < 1 || NR > NR_MAX) begin : g_bad_nr
        $error("key_schedule: NR=%0d outside 1..%0d", NR, NR_MAX);
    end
    if ((1 << IDX_W) <= NR) begin : g_bad_idx_w
        $error("key_schedule: IDX_W=%0d too narrow for NR=%0d", IDX_W, NR);
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

    ks_state_t        st;
    state_t           rk_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q, ready_q, last_q;

    logic [IDX_W-1:0] idx_inc, end_idx;
    logic             hs;
    logic [127:0]     cur;
    word_t            w0, w1, w2, w3, rot, sw, t, n0, n1, n2, n3;
    logic [3:0]       rc_i;
    logic [7:0]       rc;
    state_t           rk_nxt;

    assign hs      = valid_q && bus.rk_ready;
    assign idx_inc = idx_q + 1'b1;

    // Word 0 is in the MSBs.
    assign cur = rk_q;
    assign w0  = cur[127:96];
    assign w1  = cur[95:64];
    assign w2  = cur[63:32];
    assign w3  = cur[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    ks_subword u_subword (.w(rot), .o(sw));

    // When idx == NR, Rcon[idx+1] is out of range. The next key is not
    // used in that case, so the constant is forced to 0.
    always_comb begin
        rc_i = 4'(idx_inc);
        rc   = 8'h00;
        if (rc_i >= 4'd1 && rc_i <= 4'(NR_MAX)) rc = RCON[rc_i];
    end

    assign t      = sw ^ {rc, 24'h0};
    assign n0     = w0 ^ t;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;
    assign rk_nxt = {n0, n1, n2, n3};

`ifdef KSCHED_CACHE_EN
    state_t           cache [0:NR];
    logic             cache_ok, play_q, rev_q;
    logic [IDX_W-1:0] idx_dec;

    assign idx_dec = idx_q - 1'b1;
    assign end_idx = rev_q ? '0 : LAST;

    // Each emitted key is captured on its handshake. Replay writes nothing.
    always_ff @(posedge clk) begin
        if (st == KS_EMIT && hs && !play_q) cache[idx_q] <= rk_q;
    end
`else
    assign end_idx = LAST;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= KS_IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
`ifdef KSCHED_CACHE_EN
            cache_ok <= 1'b0;
            play_q   <= 1'b0;
            rev_q    <= 1'b0;
`endif
        end else begin
            case (st)
                KS_IDLE: begin
                    if (bus.in_valid && ready_q) begin
                        st      <= KS_EMIT;
                        rk_q    <= bus.key_in;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
`ifdef KSCHED_CACHE_EN
                        cache_ok <= 1'b0;
                        play_q   <= 1'b0;
                        rev_q    <= 1'b0;
                    end else if (bus.replay && cache_ok) begin
                        st      <= KS_EMIT;
                        rk_q    <= bus.rev ? cache[NR] : cache[0];
                        idx_q   <= bus.rev ? LAST : '0;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                        play_q  <= 1'b1;
                        rev_q   <= bus.rev;
`endif
                    end
                end
                KS_EMIT: begin
                    if (hs) begin
                        if (idx_q == end_idx) begin
                            st      <= KS_IDLE;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            last_q  <= 1'b0;
`ifdef KSCHED_CACHE_EN
                            cache_ok <= 1'b1;
                            play_q   <= 1'b0;
                        end else if (play_q && rev_q) begin
                            rk_q   <= cache[idx_dec];
                            idx_q  <= idx_dec;
                            last_q <= (idx_dec == '0);
                        end else begin
                            rk_q   <= play_q ? cache[idx_inc] : rk_nxt;
                            idx_q  <= idx_inc;
                            last_q <= (idx_inc == LAST);
`else
                        end else begin
                            rk_q   <= rk_nxt;
                            idx_q  <= idx_inc;
                            last_q <= (idx_inc == LAST);
`endif
                        end
                    end
                end
                default: st <= KS_IDLE;
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.rk_valid = valid_q;
    assign bus.rk       = rk_q;
    assign bus.rk_idx   = idx_q;
    assign bus.rk_last  = last_q;
endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;
    import cryptarch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    logic [127:0] kf [0:10];

    key_schedule_if #(.IDX_W(4)) bus ();
    key_schedule #(.NR(10), .IDX_W(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_key(input string tag, input logic [127:0] exp_rk, input int exp_idx, input bit exp_last);
        chk({tag, "_rk"},    bus.rk,                exp_rk);
        chk({tag, "_idx"},   128'(bus.rk_idx),      128'(exp_idx));
        chk({tag, "_valid"}, 128'(bus.rk_valid),    128'(1));
        chk({tag, "_last"},  128'(bus.rk_last),     128'(exp_last));
        chk({tag, "_inrdy"}, 128'(bus.in_ready),    128'(0));
    endtask

    task automatic chk_idle(input string tag, input logic [127:0] exp_rk);
        chk({tag, "_rk"},    bus.rk,             exp_rk);
        chk({tag, "_idx"},   128'(bus.rk_idx),   128'(0));
        chk({tag, "_valid"}, 128'(bus.rk_valid), 128'(0));
        chk({tag, "_last"},  128'(bus.rk_last),  128'(0));
        chk({tag, "_inrdy"}, 128'(bus.in_ready), 128'(1));
    endtask

    task automatic load(input logic [127:0] k);
        bus.key_in   = k;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && !bus.in_ready; n++) step();
        chk({tag, "_drained"}, 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        kf = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
               128'ha0fafe17_88542cb1_23a33939_2a6c7605,
               128'hf2c295f2_7a96b943_5935807a_7359f67f,
               128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
               128'hef44a541_a8525b7f_b671253b_db0bad00,
               128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
               128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
               128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
               128'head27321_b58dbad2_312bf560_7f8d292f,
               128'hac7766f3_19fadc21_28d12941_575c006e,
               128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
        bus.in_valid = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b1;
`ifdef KSCHED_CACHE_EN
        bus.replay   = 1'b0;
        bus.rev      = 1'b0;
`endif

        // reset state
        rst = 1'b1;
        step();
        step();
        chk_idle("reset", '0);
        rst = 1'b0;

        // FIPS-197 key at full throughput
        load(KEY);
        for (int i = 0; i <= 10; i++) begin
            chk_key($sformatf("t1_k%0d", i), kf[i], i, i == 10);
            step();
        end
        chk_idle("t1_end", kf[10]);

        // all-zero key
        load('0);
        chk_key("t2_k0", '0, 0, 1'b0);
        step();
        chk_key("t2_k1", 128'h62636363_62636363_62636363_62636363, 1, 1'b0);
        step();
        chk_key("t2_k2", 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa, 2, 1'b0);
        step();
        drain("t2");

        // backpressure: stalls at idx4 (3 cycles), idx7 (1), idx10 (2)
        load(KEY);
        for (int i = 0; i <= 10; i++) begin
            int stall;
            stall = (i == 4) ? 3 : (i == 7) ? 1 : (i == 10) ? 2 : 0;
            chk_key($sformatf("t3_k%0d", i), kf[i], i, i == 10);
            if (stall > 0) begin
                bus.rk_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    step();
                    chk_key($sformatf("t3_hold%0d", i), kf[i], i, i == 10);
                end
                bus.rk_ready = 1'b1;
            end
            step();
        end
        chk_idle("t3_end", kf[10]);

        // in_valid during EMIT is ignored; a held offer lands one cycle after the end
        load(KEY);
        for (int i = 0; i <= 10; i++) begin
            chk_key($sformatf("t4_k%0d", i), kf[i], i, i == 10);
            if (i == 3) begin bus.key_in = '0;  bus.in_valid = 1'b1; end
            if (i == 5) begin bus.key_in = KEY; bus.in_valid = 1'b0; end
            if (i == 8) begin bus.key_in = '0;  bus.in_valid = 1'b1; end
            step();
        end
        chk_idle("t4_gap", kf[10]);
        step();
        bus.in_valid = 1'b0;
        chk_key("t4_new", '0, 0, 1'b0);
        drain("t4");

        // reset mid-sequence at idx5
        load(KEY);
        for (int i = 0; i <= 5; i++) begin
            chk_key($sformatf("t5_k%0d", i), kf[i], i, 1'b0);
            if (i < 5) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("t5_rst", '0);
        load(KEY);
        chk_key("t5_re0", kf[0], 0, 1'b0);
        step();
        chk_key("t5_re1", kf[1], 1, 1'b0);
        step();
        drain("t5");

`ifdef KSCHED_CACHE_EN
        // reverse replay of the cached FIPS expansion
        bus.replay = 1'b1;
        bus.rev    = 1'b1;
        step();
        bus.replay = 1'b0;
        bus.rev    = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            chk_key($sformatf("t6_k%0d", i), kf[i], i, i == 0);
            step();
        end
        chk_idle("t6_end", kf[0]);

        // reset invalidates the cache, so replay is ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.replay = 1'b1;
        step();
        bus.replay = 1'b0;
        chk_idle("t6_norep", '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
